// File: rtl/channel_window_averager_pkg.sv
// Shared sizing constants and FSM encoding for the per-channel moving-average block.
package channel_avg_pkg;

  localparam int NUM_CHANNELS = 7;
  localparam int SAMPLE_BITS  = 8;
  localparam int WINDOW       = 10;
  localparam int SUM_BITS     = 12;
  localparam int CHAN_BITS    = 3;
  localparam int MAX_SUM      = WINDOW * ((1 << SAMPLE_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DIVIDE,
    OUT
  } state_t;

endpackage

// File: rtl/channel_window_averager_divider.sv
// Bit-serial restoring divider by the constant WINDOW; one quotient bit per cycle.
module window_divider
  import channel_avg_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [SUM_BITS-1:0] dividend,
  output logic                busy,
  output logic                done,
  output logic [SUM_BITS-1:0] quotient,
  output logic [SUM_BITS-1:0] remainder
);

  localparam int CNT_W = $clog2(SUM_BITS + 1);
  localparam logic [SUM_BITS:0] DIVISOR = (SUM_BITS + 1)'(WINDOW);

  logic [SUM_BITS-1:0] quo_p1;
  logic [SUM_BITS-1:0] rem_p1;
  logic [CNT_W-1:0]    cnt;
  logic [SUM_BITS:0]   trial;
  logic                fits;
  logic [SUM_BITS-1:0] quo_next;
  logic [SUM_BITS-1:0] rem_next;

  always_comb begin
    trial    = {rem_p1, quo_p1[SUM_BITS-1]};
    fits     = (trial >= DIVISOR);
    rem_next = fits ? SUM_BITS'(trial - DIVISOR) : trial[SUM_BITS-1:0];
    quo_next = {quo_p1[SUM_BITS-2:0], fits};
  end

  // Results are taken combinationally in the done cycle so the caller sees them on the final edge.
  assign done      = busy && (cnt == CNT_W'(1));
  assign quotient  = quo_next;
  assign remainder = rem_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(SUM_BITS);
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

  // ---- p1: shift/subtract datapath ----
  always_ff @(posedge clk) begin
    if (start) begin
      quo_p1 <= dividend;
      rem_p1 <= '0;
    end else if (busy) begin
      quo_p1 <= quo_next;
      rem_p1 <= rem_next;
    end
  end

endmodule

// File: rtl/channel_window_averager.sv
// Per-channel running window sum with saturating update and serial divide to a moving average.
module channel_window_averager
  import channel_avg_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHAN_BITS-1:0]   in_chan,
  input  logic [SAMPLE_BITS-1:0] in_new,
  input  logic [SAMPLE_BITS-1:0] in_old,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHAN_BITS-1:0]   out_chan,
  output logic [SUM_BITS-1:0]    out_sum,
  output logic [SAMPLE_BITS-1:0] out_avg,
  output logic                   err
);

  localparam int T_W = SUM_BITS + 2;
  localparam logic signed [T_W-1:0] MAX_SUM_S = T_W'(MAX_SUM);

  function automatic logic [SUM_BITS-1:0] sat_sum(input logic signed [T_W-1:0] v);
    if (v[T_W-1]) return '0;
    if (v > MAX_SUM_S) return SUM_BITS'(MAX_SUM);
    return v[SUM_BITS-1:0];
  endfunction

  function automatic logic sat_hit(input logic signed [T_W-1:0] v);
    return v[T_W-1] || (v > MAX_SUM_S);
  endfunction

  state_t state, state_next;

  logic [CHAN_BITS-1:0]   chan_p0;
  logic [SAMPLE_BITS-1:0] new_p0;
  logic [SAMPLE_BITS-1:0] old_p0;
  logic [SUM_BITS-1:0]    sums [NUM_CHANNELS];
  logic [SUM_BITS-1:0]    sum_p1;
  logic                   chan_ok;
  logic [SUM_BITS-1:0]    cur_sum;
  logic signed [T_W-1:0]  t_p0;
  logic [SUM_BITS-1:0]    clamped;

  logic                   div_start;
  logic                   div_busy;
  logic                   div_done;
  logic [SUM_BITS-1:0]    div_quotient;
  logic [SUM_BITS-1:0]    div_remainder;
  logic                   unused_div;

  assign unused_div = ^{div_busy, div_remainder, div_quotient[SUM_BITS-1:SAMPLE_BITS]};

  window_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (clamped),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  always_comb begin
    chan_ok = (int'(chan_p0) < NUM_CHANNELS);
    cur_sum = '0;
    if (chan_ok) cur_sum = sums[chan_p0];
    t_p0    = $signed({2'b00, cur_sum}) + $signed(T_W'(new_p0)) - $signed(T_W'(old_p0));
    clamped = sat_sum(t_p0);
  end

  always_comb begin
    state_next = state;
    div_start  = 1'b0;
    case (state)
      IDLE:   if (in_valid) state_next = UPDATE;
      UPDATE: begin
        if (chan_ok) begin
          state_next = DIVIDE;
          div_start  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      DIVIDE: if (div_done) state_next = OUT;
      OUT:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---- p0: capture accepted update ----
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      chan_p0 <= in_chan;
      new_p0  <= in_new;
      old_p0  <= in_old;
    end
  end

  // ---- p1: saturating sum write-back ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) sums[i] <= '0;
      err <= 1'b0;
    end else if (state == UPDATE) begin
      if (!chan_ok) begin
        err <= 1'b1;
      end else begin
        sums[chan_p0] <= clamped;
        if (sat_hit(t_p0)) err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == UPDATE) sum_p1 <= clamped;
  end

  // ---- p2: result registers, held until the next completed divide ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_chan <= '0;
      out_sum  <= '0;
      out_avg  <= '0;
    end else if (state == DIVIDE && div_done) begin
      out_chan <= chan_p0;
      out_sum  <= sum_p1;
      out_avg  <= div_quotient[SAMPLE_BITS-1:0];
    end
  end

endmodule

// File: tb/tb_channel_window_averager.sv
// Bench for channel_window_averager: directed scenarios plus random traffic against a sum model.
module tb_channel_window_averager;
  import channel_avg_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [CHAN_BITS-1:0]   in_chan = '0;
  logic [SAMPLE_BITS-1:0] in_new = '0;
  logic [SAMPLE_BITS-1:0] in_old = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [CHAN_BITS-1:0]   out_chan;
  logic [SUM_BITS-1:0]    out_sum;
  logic [SAMPLE_BITS-1:0] out_avg;
  logic                   err;

  always #5 clk = ~clk;

  channel_window_averager dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chan   (in_chan),
    .in_new    (in_new),
    .in_old    (in_old),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chan  (out_chan),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .err       (err)
  );

  typedef struct {
    int chan;
    int sum;
    int avg;
  } exp_t;

  exp_t exp_q[$];
  int   model_sum [8];
  bit   model_err;
  int   checks = 0;
  int   errors = 0;
  bit   tb_done = 1'b0;
  bit   rand_bp = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_apply(input int ch, input int nw, input int od);
    int   t;
    exp_t e;
    if (ch >= NUM_CHANNELS) begin
      model_err = 1'b1;
    end else begin
      t = model_sum[ch] + nw - od;
      if (t < 0) begin
        t = 0;
        model_err = 1'b1;
      end else if (t > MAX_SUM) begin
        t = MAX_SUM;
        model_err = 1'b1;
      end
      model_sum[ch] = t;
      e.chan = ch;
      e.sum  = t;
      e.avg  = t / WINDOW;
      exp_q.push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_sum[i] = 0;
    model_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input int ch, input int nw, input int od);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", int'(in_ready), 1);
      return;
    end
    in_valid = 1'b1;
    in_chan  = 3'(ch);
    in_new   = 8'(nw);
    in_old   = 8'(od);
    @(posedge clk);
    model_apply(ch, nw, od);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    if (!out_valid) chk("out_valid_timeout", int'(out_valid), 1);
  endtask

  initial begin
    fork
      // Compare process: every completed output handshake, plus hold stability while stalled.
      begin
        exp_t e;
        bit   held = 1'b0;
        int   h_chan, h_sum, h_avg;
        while (!tb_done) begin
          @(negedge clk);
          if (rand_bp) out_ready = ($urandom_range(0, 2) != 0);
          if (!reset && out_valid) begin
            if (held) begin
              chk("hold_chan", int'(out_chan), h_chan);
              chk("hold_sum", int'(out_sum), h_sum);
              chk("hold_avg", int'(out_avg), h_avg);
              chk("hold_in_ready", int'(in_ready), 0);
            end
            if (out_ready) begin
              if (exp_q.size() == 0) begin
                chk("unexpected_result", exp_q.size(), 1);
              end else begin
                e = exp_q.pop_front();
                chk("res_chan", int'(out_chan), e.chan);
                chk("res_sum", int'(out_sum), e.sum);
                chk("res_avg", int'(out_avg), e.avg);
                chk("res_err", int'(err), int'(model_err));
              end
              held = 1'b0;
            end else begin
              held   = 1'b1;
              h_chan = int'(out_chan);
              h_sum  = int'(out_sum);
              h_avg  = int'(out_avg);
            end
          end else begin
            held = 1'b0;
          end
        end
      end

      begin
        int n;
        int seen;
        int ch, nw, od;
        int s0 [3] = '{40, 80, 120};
        int a0 [3] = '{4, 8, 12};
        int s6 [3] = '{7, 14, 21};
        int a6 [3] = '{0, 1, 2};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_chan", int'(out_chan), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_out_avg", int'(out_avg), 0);
        chk("rst_err", int'(err), 0);

        send(0, 100, 0);
        wait_valid(n);
        chk("basic_latency", n, 13);
        chk("basic_chan", int'(out_chan), 0);
        chk("basic_sum", int'(out_sum), 100);
        chk("basic_avg", int'(out_avg), 10);
        chk("basic_err", int'(err), 0);

        for (int i = 0; i < 10; i++) begin
          send(3, 255, 0);
          wait_valid(n);
        end
        chk("fill_sum", int'(out_sum), 2550);
        chk("fill_avg", int'(out_avg), 255);
        chk("fill_err", int'(err), 0);
        send(3, 0, 255);
        wait_valid(n);
        chk("slide_sum", int'(out_sum), 2295);
        chk("slide_avg", int'(out_avg), 229);

        @(posedge clk);
        #1 out_ready = 1'b0;
        send(1, 30, 0);
        wait_valid(n);
        repeat (5) begin
          @(negedge clk);
          chk("bp_out_valid", int'(out_valid), 1);
          chk("bp_in_ready", int'(in_ready), 0);
          chk("bp_sum", int'(out_sum), 30);
          chk("bp_avg", int'(out_avg), 3);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_ready", int'(in_ready), 1);

        do_reset();
        for (int i = 0; i < 3; i++) begin
          send(0, 40, 0);
          wait_valid(n);
          chk("indep_ch0_sum", int'(out_sum), s0[i]);
          chk("indep_ch0_avg", int'(out_avg), a0[i]);
          send(6, 7, 0);
          wait_valid(n);
          chk("indep_ch6_chan", int'(out_chan), 6);
          chk("indep_ch6_sum", int'(out_sum), s6[i]);
          chk("indep_ch6_avg", int'(out_avg), a6[i]);
        end

        send(2, 0, 5);
        wait_valid(n);
        chk("uflow_sum", int'(out_sum), 0);
        chk("uflow_avg", int'(out_avg), 0);
        chk("uflow_err", int'(err), 1);
        send(2, 10, 0);
        wait_valid(n);
        chk("uflow_err_sticky", int'(err), 1);
        chk("uflow_next_sum", int'(out_sum), 10);

        do_reset();
        send(0, 50, 0);
        wait_valid(n);
        send(7, 9, 0);
        seen = 0;
        repeat (20) begin
          @(negedge clk);
          if (out_valid) seen++;
        end
        chk("badchan_no_output", seen, 0);
        chk("badchan_err", int'(err), 1);
        send(0, 0, 0);
        wait_valid(n);
        chk("badchan_sum_kept", int'(out_sum), 50);

        send(1, 200, 0);
        repeat (5) @(posedge clk);
        do_reset();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_err", int'(err), 0);
        send(0, 50, 0);
        wait_valid(n);
        chk("midrst_next_sum", int'(out_sum), 50);
        chk("midrst_next_avg", int'(out_avg), 5);

        @(posedge clk);
        #1 rand_bp = 1'b1;
        repeat (300) begin
          ch = int'($urandom_range(0, 7));
          nw = int'($urandom_range(0, 255));
          od = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0;
          send(ch, nw, od);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("drain", exp_q.size(), 0);
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        tb_done   = 1'b1;
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
